// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_capture                                                      |
// | Measures an external PWM waveform: period, high time and duty (0.1 %).     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_capture #(
    parameter int SYS_FREQ    = 125,
    parameter int CNT_W       = 27,
    parameter int TIMEOUT_CYC = SYS_FREQ * 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [9:0]       duty,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);
    localparam int               DW      = CNT_W + 10;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [DW-1:0]    K1000   = DW'(1000);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_LOAD = 2'd1,
        DV_ITER = 2'd2
    } div_t;

    logic [2:0]       sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    div_t             dv_q, dv_d;
    logic [CNT_W-1:0] op_p_q, op_p_d;
    logic [CNT_W-1:0] op_h_q, op_h_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    dsh_q, dsh_d;
    logic [8:0]       quo_q, quo_d;
    logic [3:0]       it_q, it_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [9:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             overrun_q, overrun_d;

    logic in_s;
    logic rise;
    logic snap;
    logic div_busy;
    logic ge;

    assign in_s     = sync_q[1];
    assign rise     = sync_q[1] & ~sync_q[2];
    assign div_busy = (dv_q != DV_IDLE);
    assign ge       = (rem_q >= dsh_q);

    always_comb begin
        state_d   = state_q;
        p_cnt_d   = p_cnt_q;
        h_cnt_d   = h_cnt_q;
        dv_d      = dv_q;
        op_p_d    = op_p_q;
        op_h_d    = op_h_q;
        rem_d     = rem_q;
        dsh_d     = dsh_q;
        quo_d     = quo_q;
        it_d      = it_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;
        overrun_d = 1'b0;
        snap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                p_cnt_d = '0;
                h_cnt_d = '0;
                if (rise) begin
                    p_cnt_d = ONE;
                    h_cnt_d = ONE;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    // Restart on the rise cycle itself so consecutive periods lose nothing
                    p_cnt_d = ONE;
                    h_cnt_d = ONE;
                    if (div_busy) overrun_d = 1'b1;
                    else          snap      = 1'b1;
                end else if (p_cnt_q >= TIMEOUT) begin
                    state_d  = ST_STUCK;
                    p_cnt_d  = '0;
                    h_cnt_d  = '0;
                    period_d = '0;
                    high_d   = '0;
                    duty_d   = in_s ? 10'd1000 : 10'd0;
                    stuck_d  = 1'b1;
                    valid_d  = 1'b1;
                end else begin
                    p_cnt_d = p_cnt_q + ONE;
                    if (in_s) h_cnt_d = h_cnt_q + ONE;
                end
            end
            ST_STUCK: begin
                p_cnt_d = '0;
                h_cnt_d = '0;
                if (rise) begin
                    stuck_d = 1'b0;
                    p_cnt_d = ONE;
                    h_cnt_d = ONE;
                    state_d = ST_MEASURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (dv_q)
            DV_IDLE: begin
                if (snap) begin
                    op_p_d = p_cnt_q;
                    op_h_d = h_cnt_q;
                    dv_d   = DV_LOAD;
                end
            end
            DV_LOAD: begin
                // Quotient is at most 1000, so aligning the divisor at bit 9 suffices
                rem_d = DW'(op_h_q) * K1000;
                dsh_d = DW'(op_p_q) << 9;
                quo_d = '0;
                it_d  = 4'd0;
                dv_d  = DV_ITER;
            end
            DV_ITER: begin
                if (ge) rem_d = rem_q - dsh_q;
                dsh_d = dsh_q >> 1;
                quo_d = {quo_q[7:0], ge};
                it_d  = it_q + 4'd1;
                if (it_q == 4'd9) begin
                    dv_d     = DV_IDLE;
                    period_d = op_p_q;
                    high_d   = op_h_q;
                    duty_d   = {quo_q, ge};
                    valid_d  = 1'b1;
                end
            end
            default: dv_d = DV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            p_cnt_q   <= '0;
            h_cnt_q   <= '0;
            dv_q      <= DV_IDLE;
            op_p_q    <= '0;
            op_h_q    <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            quo_q     <= '0;
            it_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], pwm_in};
            state_q   <= state_d;
            p_cnt_q   <= p_cnt_d;
            h_cnt_q   <= h_cnt_d;
            dv_q      <= dv_d;
            op_p_q    <= op_p_d;
            op_h_q    <= op_h_d;
            rem_q     <= rem_d;
            dsh_q     <= dsh_d;
            quo_q     <= quo_d;
            it_q      <= it_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            overrun_q <= overrun_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign duty      = duty_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pwm_capture                                                   |
// | Scoreboard bench for pwm_capture with a reduced stuck timeout.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;
    localparam int CNT_W = 27;
    localparam int TMO   = 5000;

    logic             clk;
    logic             reset_n;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [9:0]       duty;
    logic             valid;
    logic             stuck;
    logic             overrun;

    pwm_capture #(
        .SYS_FREQ   (125),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pwm_in   (pwm_in),
        .period   (period),
        .high_time(high_time),
        .duty     (duty),
        .valid    (valid),
        .stuck    (stuck),
        .overrun  (overrun)
    );

    typedef struct {
        int per;
        int hi;
        int dty;
        bit stk;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   total     = 0;
    int   bad       = 0;
    int   now       = 0;
    int   last_rise = 0;
    int   last_snap = 0;
    int   prev_hi   = 0;
    bit   armed     = 0;
    bit   snap_seen = 0;
    int   exp_ovr   = 0;
    int   ovr_seen  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            now++;
        end
    endtask

    // A rise closes the previous period; the divider accepts it only 12+ cycles after its last accepted sample
    task automatic note_rise(input int hi);
        exp_t e;
        if (armed) begin
            if (!snap_seen || (now - last_snap) >= 12) begin
                e.per = now - last_rise;
                e.hi  = prev_hi;
                e.dty = (prev_hi * 1000) / e.per;
                e.stk = 1'b0;
                exp_q.push_back(e);
                last_snap = now;
                snap_seen = 1'b1;
            end else begin
                exp_ovr++;
            end
        end
        armed     = 1'b1;
        last_rise = now;
        prev_hi   = hi;
    endtask

    task automatic push_stuck(input bit lvl);
        exp_t e;
        e.per = 0;
        e.hi  = 0;
        e.dty = lvl ? 1000 : 0;
        e.stk = 1'b1;
        exp_q.push_back(e);
        armed     = 1'b0;
        snap_seen = 1'b0;
    endtask

    task automatic drive_period(input int per, input int hi);
        pwm_in = 1'b1;
        note_rise(hi);
        tick(hi);
        pwm_in = 1'b0;
        tick(per - hi);
    endtask

    task automatic final_rise();
        pwm_in = 1'b1;
        note_rise(0);
        tick(3);
        pwm_in = 1'b0;
    endtask

    task automatic do_reset(input bit check_zero);
        pwm_in  = 1'b0;
        reset_n = 1'b0;
        tick(1);
        if (check_zero) begin
            chk("rst_period", period, 0);
            chk("rst_high", high_time, 0);
            chk("rst_duty", duty, 0);
            chk("rst_valid", valid, 0);
            chk("rst_stuck", stuck, 0);
            chk("rst_overrun", overrun, 0);
        end
        reset_n = 1'b1;
        exp_q.delete();
        armed     = 1'b0;
        snap_seen = 1'b0;
        exp_ovr   = 0;
        ovr_seen  = 0;
        tick(4);
    endtask

    task automatic finish_scn();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        tick(5);
        chk("overrun_cnt", ovr_seen, exp_ovr);
    endtask

    always @(negedge clk) begin
        if (overrun) ovr_seen++;
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                m = exp_q.pop_front();
                chk("period", period, m.per);
                chk("high_time", high_time, m.hi);
                chk("duty", duty, m.dty);
                chk("stuck", stuck, m.stk);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        tick(2);
        do_reset(1'b1);

        // Basic 70 % wave
        repeat (3) drive_period(1000, 700);
        final_rise();
        finish_scn();

        // Floor rounding, 50 %, tiny duty and minimum measurable period
        do_reset(1'b0);
        repeat (2) drive_period(300, 100);
        repeat (2) drive_period(500, 250);
        drive_period(1000, 1);
        repeat (3) drive_period(12, 11);
        final_rise();
        finish_scn();

        // Stuck high, recovery, then stuck low
        do_reset(1'b0);
        pwm_in = 1'b1;
        note_rise(0);
        push_stuck(1'b1);
        tick(TMO + 100);
        chk("stuck_hi_level", stuck, 1);
        pwm_in = 1'b0;
        tick(20);
        pwm_in = 1'b1;
        note_rise(80);
        tick(6);
        chk("stuck_clear", stuck, 0);
        tick(74);
        pwm_in = 1'b0;
        tick(120);
        pwm_in = 1'b1;
        note_rise(50);
        push_stuck(1'b0);
        tick(50);
        pwm_in = 1'b0;
        tick(TMO + 100);
        chk("stuck_lo_level", stuck, 1);
        finish_scn();

        // Periods too short for the divider
        do_reset(1'b0);
        repeat (8) drive_period(10, 5);
        repeat (4) drive_period(11, 5);
        final_rise();
        finish_scn();

        // Reset in the middle of a divide
        do_reset(1'b0);
        repeat (2) drive_period(100, 40);
        pwm_in = 1'b1;
        note_rise(0);
        tick(5);
        do_reset(1'b1);
        tick(40);
        repeat (2) drive_period(150, 60);
        final_rise();
        finish_scn();

        // Scaled loop-back style 30 % wave
        do_reset(1'b0);
        repeat (4) drive_period(1250, 375);
        final_rise();
        finish_scn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
